// File: rtl/sonic_ranger_multi.sv
// sonic_ranger_multi
// Round-robin ultrasonic ranging engine for N_CH HC-SR04-class sensors.
// Each channel owns one fixed-length slot: trigger pulse, wait for the echo,
// time the echo in microseconds, convert to cm and publish per-channel flags.

module sonic_ranger_multi #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int N_CH    = 3,
  parameter int DIST_W  = 10,
  parameter int TRIG_US = 10,
  parameter int SLOT_US = 60000,
  parameter int MAX_CM  = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIST_W-1:0]        near_cm,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trig,
  output logic [N_CH*DIST_W-1:0]   distance,
  output logic [N_CH-1:0]          valid,
  output logic [N_CH-1:0]          timeout,
  output logic [N_CH-1:0]          near,
  output logic [2:0]               cur_ch
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EW  = $clog2(SLOT_US + 1);
  localparam int PW  = EW + 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_DONE      = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t                  state_r, state_n, slot_next_s;
  logic [TW-1:0]           tick_cnt_r;
  logic [EW-1:0]           slot_us_r;
  logic [EW-1:0]           echo_us_r;
  logic [N_CH-1:0]         sync1_r, sync2_r, sync3_r;
  logic [2:0]              cur_ch_r;
  logic                    slot_over_r;
  logic [N_CH-1:0]         trig_r, valid_r, timeout_r, near_r;
  logic [N_CH*DIST_W-1:0]  dist_r;

  logic [N_CH-1:0]         ch_onehot_s;
  logic                    us_tick_s, slot_end_s, rise_s, fall_s;
  logic                    start_s, adv_s, wr_done_s, wr_to_s;
  logic [PW-1:0]           product_s, cm_full_s;
  logic [DIST_W-1:0]       cm_s;

  assign ch_onehot_s = N_CH'(1) << cur_ch_r;
  assign us_tick_s   = (state_r != S_IDLE) && (tick_cnt_r == TW'(DIV - 1));
  assign slot_end_s  = us_tick_s && (slot_us_r == EW'(SLOT_US - 1));
  // Edges only count for the channel that owns the slot.
  assign rise_s      = |(sync2_r & ~sync3_r & ch_onehot_s);
  assign fall_s      = |(~sync2_r & sync3_r & ch_onehot_s);
  assign slot_next_s = enable ? S_TRIG : S_IDLE;
  assign start_s     = (state_n == S_TRIG) && (state_r != S_TRIG);

  // Round-trip time to cm: us * 0.017, widened so the product never overflows.
  assign product_s = PW'(echo_us_r) * PW'(34);
  assign cm_full_s = product_s / PW'(2000);
  assign cm_s      = (cm_full_s > PW'(MAX_CM)) ? DIST_W'(MAX_CM) : cm_full_s[DIST_W-1:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_n;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n   = state_r;
    adv_s     = 1'b0;
    wr_done_s = 1'b0;
    wr_to_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (enable) state_n = S_TRIG;
        else        state_n = S_IDLE;
      end
      S_TRIG: begin
        if (us_tick_s && (slot_us_r == EW'(TRIG_US - 1))) state_n = S_WAIT_RISE;
        else                                              state_n = S_TRIG;
      end
      S_WAIT_RISE: begin
        if (slot_end_s) begin
          wr_to_s = 1'b1;
          adv_s   = 1'b1;
          state_n = slot_next_s;
        end else if (rise_s) begin
          state_n = S_MEASURE;
        end else begin
          state_n = S_WAIT_RISE;
        end
      end
      S_MEASURE: begin
        // A falling edge on the slot's last cycle still counts as a result.
        if (fall_s) begin
          state_n = S_DONE;
        end else if (slot_end_s) begin
          wr_to_s = 1'b1;
          adv_s   = 1'b1;
          state_n = slot_next_s;
        end else begin
          state_n = S_MEASURE;
        end
      end
      S_DONE: begin
        wr_done_s = 1'b1;
        if (slot_over_r || slot_end_s) begin
          adv_s   = 1'b1;
          state_n = slot_next_s;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (slot_end_s) begin
          adv_s   = 1'b1;
          state_n = slot_next_s;
        end else begin
          state_n = S_HOLD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Microsecond prescaler, restarted at every slot start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               tick_cnt_r <= '0;
    else if (start_s || state_r == S_IDLE) tick_cnt_r <= '0;
    else if (tick_cnt_r == TW'(DIV - 1))   tick_cnt_r <= '0;
    else                                   tick_cnt_r <= tick_cnt_r + TW'(1);
  end

  // Slot and echo microsecond counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_us_r <= '0;
      echo_us_r <= '0;
    end else if (start_s || state_r == S_IDLE) begin
      slot_us_r <= '0;
      echo_us_r <= '0;
    end else if (us_tick_s) begin
      slot_us_r <= slot_us_r + EW'(1);
      if (state_r == S_MEASURE) echo_us_r <= echo_us_r + EW'(1);
    end
  end

  // Remembers that the slot ran out while the final result was still pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  slot_over_r <= 1'b0;
    else if (adv_s || start_s) slot_over_r <= 1'b0;
    else if (slot_end_s)      slot_over_r <= 1'b1;
  end

  // Echo synchroniser plus edge-detect delay stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      sync3_r <= '0;
    end else begin
      sync1_r <= echo;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Channel pointer advances at every slot end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 cur_ch_r <= 3'd0;
    else if (adv_s && cur_ch_r == 3'(N_CH - 1)) cur_ch_r <= 3'd0;
    else if (adv_s)                          cur_ch_r <= cur_ch_r + 3'd1;
  end

  // Registered trigger drive for the owning channel only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    trig_r <= '0;
    else if (state_r == S_TRIG) trig_r <= ch_onehot_s;
    else                        trig_r <= '0;
  end

  // Per-channel result registers: measured value or timeout saturation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_r    <= '0;
      valid_r   <= '0;
      timeout_r <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cur_ch_r == 3'(k) && wr_done_s) begin
          dist_r[k*DIST_W +: DIST_W] <= cm_s;
          valid_r[k]                 <= 1'b1;
          timeout_r[k]               <= 1'b0;
        end else if (cur_ch_r == 3'(k) && wr_to_s) begin
          dist_r[k*DIST_W +: DIST_W] <= DIST_W'(MAX_CM);
          valid_r[k]                 <= 1'b1;
          timeout_r[k]               <= 1'b1;
        end
      end
    end
  end

  // Near-obstacle flags recomputed every cycle from registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      near_r <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        near_r[k] <= valid_r[k] & ~timeout_r[k] & (dist_r[k*DIST_W +: DIST_W] < near_cm);
      end
    end
  end

  assign trig     = trig_r;
  assign distance = dist_r;
  assign valid    = valid_r;
  assign timeout  = timeout_r;
  assign near     = near_r;
  assign cur_ch   = cur_ch_r;

endmodule

// File: tb/tb_sonic_ranger_multi.sv
// Self-checking bench for sonic_ranger_multi: directed and random slots
// checked against a per-channel result model derived from the ranging rules.

module tb_sonic_ranger_multi;

  localparam int N     = 3;
  localparam int DW    = 10;
  localparam int TRIG  = 10;
  localparam int SLOT  = 3000;
  localparam int MAXCM = 45;

  logic            clk = 1'b0;
  logic            rst, enable;
  logic [DW-1:0]   near_cm;
  logic [N-1:0]    echo, trig, valid, timeout, near;
  logic [N*DW-1:0] distance;
  logic [2:0]      cur_ch;

  int total = 0;
  int bad   = 0;

  int exp_dist [N];
  bit exp_val  [N];
  bit exp_to   [N];
  int exp_ch;

  sonic_ranger_multi #(
    .CLK_HZ(1_000_000), .N_CH(N), .DIST_W(DW), .TRIG_US(TRIG),
    .SLOT_US(SLOT), .MAX_CM(MAXCM)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .near_cm(near_cm), .echo(echo),
    .trig(trig), .distance(distance), .valid(valid), .timeout(timeout),
    .near(near), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  function automatic int model_cm(input int w);
    int c;
    c = (w * 34) / 2000;
    return (c > MAXCM) ? MAXCM : c;
  endfunction

  function automatic logic [N-1:0] model_near(input int thr);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k] = exp_val[k] && !exp_to[k] && (exp_dist[k] < thr);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic wait_trig();
    int waited;
    waited = 0;
    while (trig == '0 && waited < SLOT + 50) begin
      @(negedge clk);
      waited++;
    end
    chk("trig_start", (trig != '0), 1);
  endtask

  // Runs one slot starting at the negedge where its trigger is first seen.
  // rise_t/fall_t are negedge indices (-1 = none); exp_period 0 = no next slot.
  task automatic do_slot(input int rise_t, input int fall_t, input int drop_t,
                         input bit noise, input int exp_period);
    int ch, t, trig_cnt, period, w;
    bit overlap, complete;
    logic [N-1:0] e;
    ch = exp_ch;
    chk("slot_cur_ch", cur_ch, ch);
    t = 0; trig_cnt = 0; period = 0; overlap = 1'b0;
    while (1) begin
      e = '0;
      if (rise_t >= 0 && t >= rise_t && (fall_t < 0 || t < fall_t)) e[ch] = 1'b1;
      if (noise && t < SLOT - 50)
        for (int k = 0; k < N; k++) if (k != ch) e[k] = 1'($urandom);
      echo = e;
      if (t == drop_t) enable = 1'b0;
      if ($countones(trig) > 1) overlap = 1'b1;
      if (t < SLOT - 10 && trig[ch]) trig_cnt++;
      @(negedge clk);
      t++;
      if (t > TRIG + 5 && trig != '0) begin
        period = t;
        break;
      end
      if (t > SLOT + 10) break;
    end
    // Result model: a fall becomes visible 3 cycles after the raw edge and
    // must land no later than the slot's last cycle to count.
    complete = (rise_t >= 0) && (fall_t >= 0) && (fall_t <= SLOT - 4);
    w = fall_t - rise_t;
    exp_val[ch]  = 1'b1;
    exp_to[ch]   = !complete;
    exp_dist[ch] = complete ? model_cm(w) : MAXCM;
    exp_ch       = (ch + 1) % N;
    chk("trig_len",   trig_cnt, TRIG);
    chk("trig_overlap", overlap, 0);
    chk("slot_period", period, exp_period);
    chk("distance", distance[ch*DW +: DW], exp_dist[ch]);
    chk("valid",   valid, {exp_val[2], exp_val[1], exp_val[0]});
    chk("timeout", timeout[ch], exp_to[ch]);
    chk("near",    near, model_near(near_cm));
    chk("next_cur_ch", cur_ch, exp_ch);
  endtask

  initial begin
    int r, f, kind;
    rst = 1'b1; enable = 1'b0; near_cm = DW'(20); echo = '0;
    for (int k = 0; k < N; k++) begin exp_dist[k] = 0; exp_val[k] = 0; exp_to[k] = 0; end
    exp_ch = 0;

    // Reset with echo activity: everything stays cleared.
    repeat (20) begin @(negedge clk); echo = N'($urandom); end
    chk("rst_trig", trig, 0);
    chk("rst_distance", distance, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_near", near, 0);
    chk("rst_cur_ch", cur_ch, 0);
    echo = '0; enable = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_trig();

    // Round-robin 580/1160/1740 us -> 9/19/29 cm.
    do_slot(TRIG + 5, TRIG + 5 + 580,  -1, 1'b0, SLOT);
    do_slot(TRIG + 5, TRIG + 5 + 1160, -1, 1'b0, SLOT);
    do_slot(TRIG + 5, TRIG + 5 + 1740, -1, 1'b1, SLOT);
    // 1000 us -> 17, no echo -> timeout, 2353 us -> 40.
    do_slot(20, 20 + 1000, -1, 1'b1, SLOT);
    do_slot(-1, -1,        -1, 1'b1, SLOT);
    do_slot(20, 20 + 2353, -1, 1'b1, SLOT);
    // Overrange saturates without timeout; timeout clears; echo past slot end.
    do_slot(20, 20 + 2900, -1, 1'b0, SLOT);
    do_slot(30, 30 + 1000, -1, 1'b1, SLOT);
    do_slot(20, -1,        -1, 1'b0, SLOT);
    // Fall on the slot's last cycle wins, slot closes one cycle later;
    // one cycle later still is a timeout.
    do_slot(TRIG + 3, SLOT - 4, -1, 1'b0, SLOT + 1);
    do_slot(TRIG + 3, SLOT - 3, -1, 1'b0, SLOT);

    // Random slots (7 keeps the rotation ending on channel 0).
    for (int i = 0; i < 7; i++) begin
      kind = $urandom_range(0, 9);
      r = TRIG + 2 + $urandom_range(0, 200);
      f = r + 1 + $urandom_range(0, SLOT - 30 - r);
      if (kind == 0)      do_slot(-1, -1, -1, 1'b1, SLOT);
      else if (kind == 1) do_slot(r, -1, -1, 1'b1, SLOT);
      else                do_slot(r, f, -1, 1'($urandom), SLOT);
    end

    // Near scenario 17 / timeout / 25, enable dropped mid-measure on ch2.
    do_slot(20, 20 + 1000, -1, 1'b0, SLOT);
    do_slot(-1, -1,        -1, 1'b0, SLOT);
    do_slot(20, 20 + 1471, 200, 1'b0, 0);
    repeat (50) @(negedge clk);
    chk("idle_no_trig", trig, 0);
    chk("idle_cur_ch", cur_ch, 0);
    chk("near_thr20", near, model_near(20));
    near_cm = DW'(30);
    @(negedge clk);
    chk("near_thr30", near, model_near(30));

    // Restart, then reset in the middle of a measurement.
    enable = 1'b1;
    wait_trig();
    chk("restart_cur_ch", cur_ch, 0);
    repeat (30) @(negedge clk);
    echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_trig", trig, 0);
    chk("midrst_distance", distance, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_cur_ch", cur_ch, 0);
    echo = '0;
    repeat (5) @(negedge clk);
    chk("midrst_near", near, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonic_ranger_multi.md
# sonic_ranger_multi

Parametrised multi-channel ultrasonic ranging engine for HC-SR04-class sensors. It drives N_CH sensors in round-robin time slots so their echoes cannot cross-talk, and measures each echo pulse in microseconds. Each result is converted to centimetres and reported per channel with valid, timeout and near-obstacle flags. It sits between the sensor pins and the top-level mode/stop logic, which reads `near` per channel.

## Interface
Parameters:
- CLK_HZ, 100_000_000: system clock frequency; must be an integer multiple of 1_000_000.
- N_CH, 3: number of sensor channels, 1..8.
- DIST_W, 10: width of each distance field in cm.
- TRIG_US, 10: trigger pulse length in µs.
- SLOT_US, 60000: length of one channel slot in µs; also the echo timeout.
- MAX_CM, 400: saturation value reported on timeout or overrange.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when 1, ranging runs; when 0, the engine idles after the current slot ends.
- near_cm  in  DIST_W  obstacle threshold in cm.
- echo  in  N_CH  raw echo pins (asynchronous).
- trig  out  N_CH  trigger pins; at most one bit high at a time.
- distance  out  N_CH*DIST_W  per-channel distance in cm; channel k occupies [k*DIST_W +: DIST_W].
- valid  out  N_CH  sticky; set on the channel's first completed slot.
- timeout  out  N_CH  1 = the last slot for that channel produced no complete echo.
- near  out  N_CH  registered flag: valid & ~timeout & (distance < near_cm).
- cur_ch  out  3  channel owning the current slot.

## Operation
- Tick: a counter 0..CLK_HZ/1e6-1 produces a 1-cycle `us_tick`. The counter is free-running while not in IDLE and is cleared on entering TRIG.
- Echo: each echo bit passes through a 2-flop synchroniser. Rising and falling edges are detected from flops 2 and 3, giving 3 cycles of input latency.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, DONE, HOLD.
  - IDLE: if enable=1, go to TRIG. Clear slot_us and echo_us.
  - TRIG: trig[cur_ch]=1 for TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: on a rising edge of echo[cur_ch], go to MEASURE.
  - MEASURE: echo_us increments on each us_tick. On a falling edge, go to DONE.
  - DONE: one cycle. cm = (echo_us*34)/2000, truncated, saturated to MAX_CM. Write distance[cur_ch], set valid[cur_ch], clear timeout[cur_ch]. Go to HOLD.
  - HOLD: wait until the slot ends.
- Slot timer: slot_us counts us_ticks from TRIG entry through all states.
  - slot_us reaching SLOT_US-1 in WAIT_RISE or MEASURE: distance[cur_ch]=MAX_CM, timeout[cur_ch]=1, valid[cur_ch]=1.
  - At the end of any slot, cur_ch advances with wrap (N_CH-1 → 0). The FSM then goes to TRIG if enable=1, or to IDLE if enable=0.
- Edges on echo bits of other channels are ignored.
- Arithmetic: echo_us is ceil(log2(SLOT_US+1)) bits wide. The product uses a 6-bit-wider intermediate, so there is no overflow before the divide.
- `near` is recomputed every cycle from registered values. A change to near_cm takes effect 1 cycle later.

## Timing
- Reset values: trig=0, distance=0, valid=0, timeout=0, near=0, cur_ch=0, FSM=IDLE. Reset mid-slot drops trig within the reset assertion; no partial result is written.
- trig rises 1 cycle after TRIG is entered. It stays high for exactly TRIG_US*CLK_HZ/1e6 cycles.
- A complete slot is SLOT_US*CLK_HZ/1e6 cycles, independent of the echo. The period per channel is N_CH slots.
- distance, valid and timeout update 1 cycle after the falling edge is detected, i.e. 4 cycles after the raw echo falls. near follows 1 cycle later.
- A falling edge and the slot end on the same cycle: the falling edge wins (DONE), and the slot then ends immediately after.
- enable dropping mid-slot: the slot completes normally and its result is written, then the FSM enters IDLE with cur_ch already advanced.

## Test plan
- Reset: hold rst with random echo activity → all outputs 0. After release with enable=1, trig[0] goes high for exactly 10 µs.
- Single channel (CLK_HZ=1_000_000, N_CH=1): echo high for 1000 µs → distance=17, valid=1, timeout=0. Then 2353 µs → distance=40.
- Round-robin (N_CH=3): echoes of 580/1160/1740 µs on channels 0/1/2 → distances 9/19/29. trig bits never overlap. cur_ch sequence is 0,1,2,0.
- Timeout: no echo on channel 1 → distance[1]=400 and timeout[1]=1 at slot end. A later 1000 µs echo → 17 with timeout[1]=0.
- Near flag: near_cm=20 with channel distances 17/400(timeout)/25 → near=3'b001. Change near_cm to 30 → near=3'b101 on the following cycle.
- Enable and boundaries: deassert enable mid-measure → result written, then IDLE with no further trig. Echo still high at slot end → timeout path. Echo of 25000 µs → 425 saturated to 400 with timeout=0.
